seg7_scan_ctrl: RTL and testbench

SEG7_SCAN_CTRL -- requirements
Module: seg7_scan_ctrl

---
 rtl/seg7_scan_ctrl.sv | 179 +++++++++++++++++
 tb/tb_seg7_scan_ctrl.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/seg7_scan_ctrl.sv
// seg7_scan_ctrl: 4-digit multiplexed 7-segment scan controller.
// Each digit owns one slot of BLANK_TICKS+16 ticks, where one tick is TICK_DIV
// clocks. A slot is a blanking phase followed by an ON phase whose length
// (0..15 ticks) comes from BRIGHT, sampled at the start of the slot.
// Writes go to shadow registers. COMMIT copies shadow to active at the next
// frame boundary, or on the next clock while scanning is disabled.
// Ports:
//   CLK, RST_N            clock, asynchronous active-low reset
//   EN                    scan enable
//   WR_EN/WR_ADDR/WR_DATA shadow register write port (active-low segment data)
//   COMMIT                request a shadow-to-active copy
//   BRIGHT                ON ticks per slot
//   SEG, CS_N             registered segment bus and digit selects (active-low)
//   BUSY                  a commit is pending
//   ACK                   one-cycle pulse when the commit is applied
//   FRAME_START           one-cycle pulse on entry to digit 0, tick 0
module seg7_scan_ctrl #(
    parameter int unsigned TICK_DIV    = 1024,
    parameter int unsigned BLANK_TICKS = 2
) (
    input  logic       CLK,
    input  logic       RST_N,
    input  logic       EN,
    input  logic       WR_EN,
    input  logic [1:0] WR_ADDR,
    input  logic [7:0] WR_DATA,
    input  logic       COMMIT,
    input  logic [3:0] BRIGHT,
    output logic [7:0] SEG,
    output logic [3:0] CS_N,
    output logic       BUSY,
    output logic       ACK,
    output logic       FRAME_START
);

    localparam int unsigned PRE_W      = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int unsigned SLOT_TICKS = BLANK_TICKS + 16;
    localparam int unsigned PH_W       = $clog2(SLOT_TICKS);

    localparam logic [PRE_W-1:0] PRE_MAX  = PRE_W'(TICK_DIV - 1);
    localparam logic [PH_W-1:0]  PH_MAX   = PH_W'(SLOT_TICKS - 1);
    localparam logic [PH_W-1:0]  PH_BLANK = PH_W'(BLANK_TICKS);

    typedef enum logic {
        ST_IDLE,
        ST_SCAN
    } state_t;

    state_t           state, state_nxt;
    logic [PRE_W-1:0] pre, pre_nxt;
    logic [PH_W-1:0]  ph, ph_nxt;
    logic [1:0]       dig, dig_nxt;
    logic [3:0]       bright_l, bright_nxt;
    logic             busy_nxt, ack_nxt, fs_nxt;
    logic [7:0]       seg_nxt;
    logic [3:0]       cs_nxt;
    logic             slot_start_c, boundary_c, apply_c;

    logic [7:0] shadow [4];
    logic [7:0] active [4];

    // Next position, commit handling and the registered output image for
    // that position.
    always_comb begin
        state_nxt    = state;
        pre_nxt      = pre;
        ph_nxt       = ph;
        dig_nxt      = dig;
        bright_nxt   = bright_l;
        busy_nxt     = BUSY;
        ack_nxt      = 1'b0;
        fs_nxt       = 1'b0;
        seg_nxt      = 8'hFF;
        cs_nxt       = 4'hF;
        slot_start_c = 1'b0;
        boundary_c   = 1'b0;
        apply_c      = 1'b0;

        case (state)
            ST_IDLE: begin
                pre_nxt = '0;
                ph_nxt  = '0;
                dig_nxt = '0;
                if (EN) begin
                    state_nxt    = ST_SCAN;
                    slot_start_c = 1'b1;
                end
            end
            ST_SCAN: begin
                if (!EN) begin
                    state_nxt = ST_IDLE;
                    pre_nxt   = '0;
                    ph_nxt    = '0;
                    dig_nxt   = '0;
                end else if (pre == PRE_MAX) begin
                    pre_nxt = '0;
                    if (ph == PH_MAX) begin
                        ph_nxt       = '0;
                        dig_nxt      = dig + 2'd1;
                        slot_start_c = 1'b1;
                    end else begin
                        ph_nxt = ph + PH_W'(1);
                    end
                end else begin
                    pre_nxt = pre + PRE_W'(1);
                end
            end
            default: state_nxt = ST_IDLE;
        endcase

        boundary_c = slot_start_c && (dig_nxt == 2'd0);
        if (slot_start_c) begin
            bright_nxt = BRIGHT;
        end
        fs_nxt = boundary_c;

        // A commit raised on the applying edge is absorbed into that apply.
        apply_c = BUSY && (boundary_c || !EN);
        if (apply_c) begin
            busy_nxt = 1'b0;
            ack_nxt  = 1'b1;
        end else if (COMMIT) begin
            busy_nxt = 1'b1;
        end

        if (EN && (ph_nxt >= PH_BLANK) && ((ph_nxt - PH_BLANK) < PH_W'(bright_nxt))) begin
            cs_nxt  = ~(4'b0001 << dig_nxt);
            seg_nxt = active[dig_nxt];
        end
    end

    // State, counters and registered outputs.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state       <= ST_IDLE;
            pre         <= '0;
            ph          <= '0;
            dig         <= '0;
            bright_l    <= '0;
            BUSY        <= 1'b0;
            ACK         <= 1'b0;
            FRAME_START <= 1'b0;
            SEG         <= 8'hFF;
            CS_N        <= 4'hF;
        end else begin
            state       <= state_nxt;
            pre         <= pre_nxt;
            ph          <= ph_nxt;
            dig         <= dig_nxt;
            bright_l    <= bright_nxt;
            BUSY        <= busy_nxt;
            ACK         <= ack_nxt;
            FRAME_START <= fs_nxt;
            SEG         <= seg_nxt;
            CS_N        <= cs_nxt;
        end
    end

    // Shadow and active registers; a write coinciding with a copy lands in
    // shadow only, while active takes the pre-write value.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            for (int i = 0; i < 4; i++) begin
                shadow[i] <= 8'hFF;
                active[i] <= 8'hFF;
            end
        end else begin
            if (WR_EN) begin
                shadow[WR_ADDR] <= WR_DATA;
            end
            if (apply_c) begin
                for (int i = 0; i < 4; i++) begin
                    active[i] <= shadow[i];
                end
            end
        end
    end

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// Directed bench for seg7_scan_ctrl with TICK_DIV=4, BLANK_TICKS=2
// (72-clock slots, 288-clock frames).
module tb_seg7_scan_ctrl;

    logic       CLK;
    logic       RST_N;
    logic       EN;
    logic       WR_EN;
    logic [1:0] WR_ADDR;
    logic [7:0] WR_DATA;
    logic       COMMIT;
    logic [3:0] BRIGHT;
    logic [7:0] SEG;
    logic [3:0] CS_N;
    logic       BUSY;
    logic       ACK;
    logic       FRAME_START;

    int n_asrt = 0;
    int n_fail = 0;

    seg7_scan_ctrl #(.TICK_DIV(4), .BLANK_TICKS(2)) dut (
        .CLK(CLK), .RST_N(RST_N), .EN(EN), .WR_EN(WR_EN), .WR_ADDR(WR_ADDR),
        .WR_DATA(WR_DATA), .COMMIT(COMMIT), .BRIGHT(BRIGHT), .SEG(SEG),
        .CS_N(CS_N), .BUSY(BUSY), .ACK(ACK), .FRAME_START(FRAME_START)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_asrt++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    // One clock, then the per-cycle single-select check.
    task automatic step();
        int low;
        @(posedge CLK);
        #1;
        low = 0;
        for (int i = 0; i < 4; i++) if (CS_N[i] === 1'b0) low++;
        n_asrt++;
        assert (low <= 1) else begin
            n_fail++;
            $error("FAIL onehot: observed CS_N=%h expected at most one low bit", CS_N);
        end
    endtask

    // Check slot cycles lo..hi-1 of digit d (n=0 is the slot-entry edge),
    // stepping after each; the slot shows 8 blank clocks, 4*br on clocks, then dark.
    task automatic run_slot(input int d, input logic [7:0] s, input int br,
                            input int lo, input int hi);
        int    bad;
        string info;
        logic [3:0] e_cs;
        logic [7:0] e_seg;
        logic       e_fs;
        bad  = 0;
        info = "";
        for (int n = lo; n < hi; n++) begin
            if (n >= 8 && n < 8 + 4 * br) begin
                e_cs  = ~(4'b0001 << d);
                e_seg = s;
            end else begin
                e_cs  = 4'hF;
                e_seg = 8'hFF;
            end
            e_fs = (n == 0 && d == 0);
            if (CS_N !== e_cs || SEG !== e_seg || FRAME_START !== e_fs ||
                (n > 0 && ACK !== 1'b0)) begin
                if (bad == 0)
                    info = $sformatf("n=%0d observed CS_N=%h SEG=%h FS=%b ACK=%b expected CS_N=%h SEG=%h FS=%b",
                                     n, CS_N, SEG, FRAME_START, ACK, e_cs, e_seg, e_fs);
                bad++;
            end
            step();
        end
        n_asrt++;
        assert (bad == 0) else begin
            n_fail++;
            $error("FAIL slot d%0d: %0d bad cycles, first %s", d, bad, info);
        end
    endtask

    task automatic run_frame(input logic [7:0] s0, input logic [7:0] s1,
                             input logic [7:0] s2, input logic [7:0] s3, input int br);
        run_slot(0, s0, br, 0, 72);
        run_slot(1, s1, br, 0, 72);
        run_slot(2, s2, br, 0, 72);
        run_slot(3, s3, br, 0, 72);
    endtask

    task automatic wr(input logic [1:0] a, input logic [7:0] v);
        WR_EN = 1'b1; WR_ADDR = a; WR_DATA = v;
        step();
        WR_EN = 1'b0;
    endtask

    initial begin
        RST_N = 1'b0; EN = 1'b0; WR_EN = 1'b0; WR_ADDR = 2'd0; WR_DATA = 8'h00;
        COMMIT = 1'b0; BRIGHT = 4'd8;
        step(); step();
        chk("rst_seg", SEG, 8'hFF);
        chk("rst_cs", {4'h0, CS_N}, 8'h0F);
        chk("rst_busy", {7'd0, BUSY}, 8'h00);
        chk("rst_ack", {7'd0, ACK}, 8'h00);
        chk("rst_fs", {7'd0, FRAME_START}, 8'h00);
        RST_N = 1'b1;
        step();

        // Load and commit, then enable: commit applied at the first boundary.
        wr(2'd0, 8'hC0); wr(2'd1, 8'hF9); wr(2'd2, 8'hA4); wr(2'd3, 8'hB0);
        COMMIT = 1'b1;
        step();
        COMMIT = 1'b0;
        chk("commit_busy", {7'd0, BUSY}, 8'h01);
        EN = 1'b1;
        step();
        chk("first_ack", {7'd0, ACK}, 8'h01);
        chk("first_busy", {7'd0, BUSY}, 8'h00);

        // Frame 1 at BRIGHT=8; raise BRIGHT mid slot 3 (no effect until next slot).
        run_slot(0, 8'hC0, 8, 0, 72);
        run_slot(1, 8'hF9, 8, 0, 72);
        run_slot(2, 8'hA4, 8, 0, 72);
        run_slot(3, 8'hB0, 8, 0, 20);
        BRIGHT = 4'd15;
        run_slot(3, 8'hB0, 8, 20, 72);

        // Frame 2 at BRIGHT=15; drop to 0 mid slot 3.
        run_slot(0, 8'hC0, 15, 0, 72);
        run_slot(1, 8'hF9, 15, 0, 72);
        run_slot(2, 8'hA4, 15, 0, 72);
        run_slot(3, 8'hB0, 15, 0, 30);
        BRIGHT = 4'd0;
        run_slot(3, 8'hB0, 15, 30, 72);

        // Frame 3 fully dark.
        run_slot(0, 8'hC0, 0, 0, 72);
        run_slot(1, 8'hF9, 0, 0, 72);
        run_slot(2, 8'hA4, 0, 0, 72);
        run_slot(3, 8'hB0, 0, 0, 10);
        BRIGHT = 4'd8;
        run_slot(3, 8'hB0, 0, 10, 72);

        // Frame 4: commit mid-frame, write to digit 2 on the boundary cycle.
        run_slot(0, 8'hC0, 8, 0, 72);
        run_slot(1, 8'hF9, 8, 0, 10);
        WR_EN = 1'b1; WR_ADDR = 2'd0; WR_DATA = 8'h99;
        run_slot(1, 8'hF9, 8, 10, 11);
        WR_EN = 1'b0; COMMIT = 1'b1;
        run_slot(1, 8'hF9, 8, 11, 12);
        COMMIT = 1'b0;
        chk("mid_busy", {7'd0, BUSY}, 8'h01);
        run_slot(1, 8'hF9, 8, 12, 72);
        run_slot(2, 8'hA4, 8, 0, 72);
        run_slot(3, 8'hB0, 8, 0, 71);
        chk("pre_bound_busy", {7'd0, BUSY}, 8'h01);
        WR_EN = 1'b1; WR_ADDR = 2'd2; WR_DATA = 8'h92;
        run_slot(3, 8'hB0, 8, 71, 72);
        WR_EN = 1'b0;
        chk("bound_ack", {7'd0, ACK}, 8'h01);
        chk("bound_busy", {7'd0, BUSY}, 8'h00);

        // Frame 5: digit 2 still shows the old shadow value; commit again.
        run_slot(0, 8'h99, 8, 0, 72);
        run_slot(1, 8'hF9, 8, 0, 72);
        run_slot(2, 8'hA4, 8, 0, 5);
        COMMIT = 1'b1;
        run_slot(2, 8'hA4, 8, 5, 6);
        COMMIT = 1'b0;
        run_slot(2, 8'hA4, 8, 6, 72);
        run_slot(3, 8'hB0, 8, 0, 72);
        chk("f6_ack", {7'd0, ACK}, 8'h01);

        // Frame 6: disable mid-ON, commit while disabled, re-enable.
        run_slot(0, 8'h99, 8, 0, 21);
        EN = 1'b0;
        step();
        chk("dis_cs", {4'h0, CS_N}, 8'h0F);
        chk("dis_seg", SEG, 8'hFF);
        chk("dis_fs", {7'd0, FRAME_START}, 8'h00);
        wr(2'd1, 8'hA1);
        COMMIT = 1'b1;
        step();
        COMMIT = 1'b0;
        chk("dis_busy", {7'd0, BUSY}, 8'h01);
        chk("dis_ack0", {7'd0, ACK}, 8'h00);
        step();
        chk("dis_ack", {7'd0, ACK}, 8'h01);
        chk("dis_busy_clr", {7'd0, BUSY}, 8'h00);
        step();
        chk("dis_ack_end", {7'd0, ACK}, 8'h00);
        EN = 1'b1;
        step();
        run_frame(8'h99, 8'hA1, 8'h92, 8'hB0, 8);
        run_frame(8'h99, 8'hA1, 8'h92, 8'hB0, 8);

        // Frame 8: reset mid-ON with a commit pending.
        run_slot(0, 8'h99, 8, 0, 10);
        WR_EN = 1'b1; WR_ADDR = 2'd3; WR_DATA = 8'h00; COMMIT = 1'b1;
        run_slot(0, 8'h99, 8, 10, 11);
        WR_EN = 1'b0; COMMIT = 1'b0;
        chk("rst_pend_busy", {7'd0, BUSY}, 8'h01);
        run_slot(0, 8'h99, 8, 11, 21);
        #2;
        RST_N = 1'b0;
        #1;
        chk("arst_seg", SEG, 8'hFF);
        chk("arst_cs", {4'h0, CS_N}, 8'h0F);
        chk("arst_busy", {7'd0, BUSY}, 8'h00);
        chk("arst_fs", {7'd0, FRAME_START}, 8'h00);
        step(); step();
        RST_N = 1'b1;
        step();
        run_frame(8'hFF, 8'hFF, 8'hFF, 8'hFF, 8);
        chk("post_rst_ack", {7'd0, ACK}, 8'h00);
        chk("post_rst_busy", {7'd0, BUSY}, 8'h00);
        chk("post_rst_fs", {7'd0, FRAME_START}, 8'h01);
        run_frame(8'hFF, 8'hFF, 8'hFF, 8'hFF, 8);

        $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
        $finish;
    end

endmodule
